// File: rtl/jk_drv_pkg.sv
// Shared types and per-bit J/K encoders for the JK drive sequencer.
// Contents:
//   jk_drv_state_t        sequencer FSM state encoding
//   jk_enc_direct(t)      {j, k} that forces Q to t regardless of current Q
//   jk_enc_toggle(q, t)   {j, k} that toggles Q only where it differs from t
package jk_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRIVE,
    CHECK,
    DONE
  } jk_drv_state_t;

  // Set when t=1, reset when t=0: never j=k=1.
  function automatic logic [1:0] jk_enc_direct(input logic t);
    return {t, ~t};
  endfunction

  // Hold (00) where Q already equals t, toggle (11) where it must flip.
  function automatic logic [1:0] jk_enc_toggle(input logic q, input logic t);
    return {q ^ t, q ^ t};
  endfunction

endpackage

// File: rtl/jk_drive_sequencer_if.sv
// Bundle of control, target-stream and flop-bank signals around the sequencer.
// Signals:
//   start                        run request
//   tgt_valid/tgt_data/tgt_last  target stream into the sequencer
//   tgt_ready                    sequencer accepts a target
//   q                            Q outputs of the driven flop bank
//   j/k                          registered J/K drive
//   busy/done/mismatch           run status
//   err_count                    saturating mismatch count for the current run
// Modports:
//   master  the sequencer itself
//   slave   the environment (target source, flop bank, status consumer)
interface jk_drive_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic             start;
  logic             tgt_valid;
  logic [WIDTH-1:0] tgt_data;
  logic             tgt_last;
  logic             tgt_ready;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic [ERR_W-1:0] err_count;

  modport master (
    input  start, tgt_valid, tgt_data, tgt_last, q,
    output tgt_ready, j, k, busy, done, mismatch, err_count
  );

  modport slave (
    output start, tgt_valid, tgt_data, tgt_last, q,
    input  tgt_ready, j, k, busy, done, mismatch, err_count
  );
endinterface

// File: rtl/jk_flipflop.sv
// Single JK flip-flop, the cell driven by the sequencer.
// Ports:
//   q    out  registered output (no reset; powers up unknown)
//   j    in   set request
//   k    in   reset request
//   clk  in   clock
module jk_flipflop (
  output logic q,
  input  logic j,
  input  logic k,
  input  logic clk
);

  always_ff @(posedge clk) begin
    case ({j, k})
      2'b01:   q <= 1'b0;
      2'b10:   q <= 1'b1;
      2'b11:   q <= ~q;
      default: q <= q;
    endcase
  end

endmodule

// File: rtl/jk_drive_sequencer.sv
// Self-checking stimulus engine for a bank of WIDTH JK flip-flops.
// Each accepted target is encoded into J/K for one cycle, Q is compared
// against the target in the following cycle, and mismatches are counted.
// Ports:
//   clk  in   clock, all state updates on the rising edge
//   rst  in   synchronous active-high reset
//   bus  master modport of jk_drive_sequencer_if (see interface header)
// Parameters:
//   WIDTH       number of flops driven
//   ERR_W       width of the saturating mismatch counter
//   DRIVE_MODE  0 = direct encoding, 1 = toggle encoding after the first target
module jk_drive_sequencer
  import jk_drv_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int ERR_W      = 8,
  parameter int DRIVE_MODE = 0
) (
  input logic            clk,
  input logic            rst,
  jk_drive_sequencer_if.master bus
);

  jk_drv_state_t    state_reg, state_next;
  logic [WIDTH-1:0] tgt_reg;
  logic             last_reg;
  logic             first_reg;
  logic [ERR_W-1:0] err_reg;
  logic [WIDTH-1:0] j_reg, k_reg;
  logic             mismatch_reg;

  logic             accept;
  logic             q_bad;
  logic [WIDTH-1:0] enc_j, enc_k;

  // Encoding is computed from the incoming target and the live Q at the
  // accept edge, then registered so J/K are stable for the whole DRIVE cycle.
  // The first target of a run is always direct because Q may be unknown.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_enc
    logic [1:0] jk_bit;
    always_comb begin
      jk_bit = jk_enc_direct(bus.tgt_data[gi]);
      if (DRIVE_MODE != 0 && !first_reg) begin
        jk_bit = jk_enc_toggle(bus.q[gi], bus.tgt_data[gi]);
      end
    end
    assign enc_j[gi] = jk_bit[1];
    assign enc_k[gi] = jk_bit[0];
  end

  assign q_bad = (bus.q != tgt_reg);

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE:  if (bus.start) state_next = LOAD;
      LOAD: begin
        if (bus.tgt_valid) begin
          accept     = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: state_next = CHECK;
      CHECK: state_next = last_reg ? DONE : LOAD;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      tgt_reg      <= '0;
      last_reg     <= 1'b0;
      first_reg    <= 1'b0;
      err_reg      <= '0;
      j_reg        <= '0;
      k_reg        <= '0;
      mismatch_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      // J/K are non-zero only during DRIVE, i.e. the cycle after an accept.
      j_reg        <= accept ? enc_j : '0;
      k_reg        <= accept ? enc_k : '0;
      mismatch_reg <= (state_reg == CHECK) && q_bad;

      if (accept) begin
        tgt_reg   <= bus.tgt_data;
        last_reg  <= bus.tgt_last;
        first_reg <= 1'b0;
      end

      if (state_reg == IDLE && bus.start) begin
        err_reg   <= '0;
        first_reg <= 1'b1;
      end else if (state_reg == CHECK && q_bad && err_reg != {ERR_W{1'b1}}) begin
        err_reg <= err_reg + 1'b1;
      end
    end
  end

  assign bus.tgt_ready = (state_reg == LOAD);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == DONE);
  assign bus.mismatch  = mismatch_reg;
  assign bus.err_count = err_reg;
  assign bus.j         = j_reg;
  assign bus.k         = k_reg;

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Bench for jk_drive_sequencer: two instances (direct mode with a 2-bit
// counter, toggle mode with an 8-bit counter), each driving a bank of
// jk_flipflop cells. Expected J/K/Q/mismatch/err values are queued when a
// target is sent and compared in the DRIVE, CHECK and following cycles.
module tb_jk_drive_sequencer;

  localparam int W = 4;

  typedef struct packed {
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] q;
    logic       mm;
    logic [7:0] err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jk_drive_sequencer_if #(.WIDTH(W), .ERR_W(2)) bus_a ();
  jk_drive_sequencer_if #(.WIDTH(W), .ERR_W(8)) bus_b ();

  logic [W-1:0] flop_q_a, flop_q_b, fault_a;

  jk_drive_sequencer #(.WIDTH(W), .ERR_W(2), .DRIVE_MODE(0)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  jk_drive_sequencer #(.WIDTH(W), .ERR_W(8), .DRIVE_MODE(1)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  for (genvar gi = 0; gi < W; gi++) begin : g_ff
    jk_flipflop u_ff_a (.q(flop_q_a[gi]), .j(bus_a.j[gi]), .k(bus_a.k[gi]), .clk(clk));
    jk_flipflop u_ff_b (.q(flop_q_b[gi]), .j(bus_b.j[gi]), .k(bus_b.k[gi]), .clk(clk));
  end

  // fault_a forces selected Q bits low as seen by instance A.
  assign bus_a.q = flop_q_a & ~fault_a;
  assign bus_b.q = flop_q_b;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int done_a = 0;
  int done_b = 0;
  logic acc_a = 1'b0;
  logic acc_b = 1'b0;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t it2[2];
  exp_t it3[2];
  logic st2[2];
  logic st3[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t mk(input logic [3:0] j, input logic [3:0] k, input logic [3:0] q,
                              input logic mm, input logic [7:0] err);
    exp_t e;
    e.j = j; e.k = k; e.q = q; e.mm = mm; e.err = err;
    return e;
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    acc_a <= bus_a.tgt_valid && bus_a.tgt_ready && !rst;
    acc_b <= bus_b.tgt_valid && bus_b.tgt_ready && !rst;
  end

  // One scoreboard step per unit per falling edge:
  // DRIVE cycle -> J/K, CHECK cycle -> Q, cycle after CHECK -> mismatch/err.
  task automatic mon_step(input int u, input logic acc, input logic in_rst,
                          input logic [3:0] j, input logic [3:0] k, input logic [3:0] q,
                          input logic mm, input logic [7:0] err);
    exp_t it;
    logic got;
    got = 1'b0;
    it  = '0;
    if (!in_rst && st3[u]) begin
      check($sformatf("u%0d_mismatch", u), 32'(mm), 32'(it3[u].mm));
      check($sformatf("u%0d_err_count", u), 32'(err), 32'(it3[u].err));
    end
    if (!in_rst && st2[u]) check($sformatf("u%0d_q", u), 32'(q), 32'(it2[u].q));
    if (acc) begin
      if (u == 0 && sb_a.size() > 0) begin
        it = sb_a.pop_front(); got = 1'b1;
      end else if (u == 1 && sb_b.size() > 0) begin
        it = sb_b.pop_front(); got = 1'b1;
      end
      if (got) begin
        check($sformatf("u%0d_j", u), 32'(j), 32'(it.j));
        check($sformatf("u%0d_k", u), 32'(k), 32'(it.k));
      end else begin
        check($sformatf("u%0d_unexpected_accept", u), 1, 0);
      end
    end
    if (in_rst) begin
      st2[u] = 1'b0;
      st3[u] = 1'b0;
    end else begin
      st3[u] = st2[u];
      it3[u] = it2[u];
      st2[u] = got;
      it2[u] = it;
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, acc_a, rst, bus_a.j, bus_a.k, bus_a.q, bus_a.mismatch, 8'(bus_a.err_count));
    mon_step(1, acc_b, rst, bus_b.j, bus_b.k, bus_b.q, bus_b.mismatch, bus_b.err_count);
    if (bus_a.done) done_a++;
    if (bus_b.done) done_b++;
  end

  // Called on a falling edge; returns on the falling edge of the DRIVE cycle.
  task automatic send(input int u, input logic [3:0] data, input logic last, input exp_t e);
    int n;
    logic rdy;
    if (u == 0) begin
      sb_a.push_back(e);
      bus_a.tgt_valid = 1'b1; bus_a.tgt_data = data; bus_a.tgt_last = last;
    end else begin
      sb_b.push_back(e);
      bus_b.tgt_valid = 1'b1; bus_b.tgt_data = data; bus_b.tgt_last = last;
    end
    n = 0;
    rdy = (u == 0) ? bus_a.tgt_ready : bus_b.tgt_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
      rdy = (u == 0) ? bus_a.tgt_ready : bus_b.tgt_ready;
    end
    if (!rdy) check($sformatf("u%0d_accept_timeout", u), 0, 1);
    @(negedge clk);
    if (u == 0) bus_a.tgt_valid = 1'b0;
    else        bus_b.tgt_valid = 1'b0;
  endtask

  task automatic pulse_start(input int u, output int at);
    if (u == 0) bus_a.start = 1'b1;
    else        bus_b.start = 1'b1;
    at = cyc;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic wait_done(input int u, output int at);
    logic d;
    at = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      d = (u == 0) ? bus_a.done : bus_b.done;
      if (d) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check($sformatf("u%0d_done_timeout", u), 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, d0;
    rst = 1'b1;
    fault_a = '0;
    bus_a.start = 1'b1; bus_a.tgt_valid = 1'b0; bus_a.tgt_data = '0; bus_a.tgt_last = 1'b0;
    bus_b.start = 1'b1; bus_b.tgt_valid = 1'b0; bus_b.tgt_data = '0; bus_b.tgt_last = 1'b0;

    // Reset with start held high.
    repeat (2) @(negedge clk);
    check("rst_a_j", 32'(bus_a.j), 0);
    check("rst_a_k", 32'(bus_a.k), 0);
    check("rst_a_busy", 32'(bus_a.busy), 0);
    check("rst_a_tgt_ready", 32'(bus_a.tgt_ready), 0);
    check("rst_a_err_count", 32'(bus_a.err_count), 0);
    check("rst_b_busy", 32'(bus_b.busy), 0);
    check("rst_b_err_count", 32'(bus_b.err_count), 0);
    rst = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    @(negedge clk);
    check("post_rst_a_busy", 32'(bus_a.busy), 0);

    // Direct mode: 1010, 0101, 1111(last).
    pulse_start(0, t0);
    send(0, 4'b1010, 1'b0, mk(4'b1010, 4'b0101, 4'b1010, 1'b0, 8'd0));
    send(0, 4'b0101, 1'b0, mk(4'b0101, 4'b1010, 4'b0101, 1'b0, 8'd0));
    send(0, 4'b1111, 1'b1, mk(4'b1111, 4'b0000, 4'b1111, 1'b0, 8'd0));
    wait_done(0, t1);
    check("a_done_latency", 32'(t1 - t0), 10);
    @(negedge clk);
    check("a_done_count", 32'(done_a), 1);
    check("a_idle_after_done", 32'(bus_a.busy), 0);
    check("a_err_after_clean_run", 32'(bus_a.err_count), 0);

    // Fault on q[2]: five faulty targets saturate the 2-bit counter.
    fault_a = 4'b0100;
    pulse_start(0, t0);
    for (int i = 0; i < 5; i++) begin
      send(0, 4'b0100, (i == 4), mk(4'b0100, 4'b1011, 4'b0000, 1'b1, 8'((i + 1 > 3) ? 3 : i + 1)));
    end
    wait_done(0, t1);
    fault_a = '0;
    @(negedge clk);
    check("a_done_count_fault_run", 32'(done_a), 2);
    check("a_err_saturated", 32'(bus_a.err_count), 3);

    // Stall in LOAD, start while busy, then reset during DRIVE.
    pulse_start(0, t0);
    check("a_err_cleared_on_start", 32'(bus_a.err_count), 0);
    fault_a = 4'b0100;
    send(0, 4'b0100, 1'b0, mk(4'b0100, 4'b1011, 4'b0000, 1'b1, 8'd1));
    repeat (2) @(negedge clk);
    fault_a = '0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall%0d_tgt_ready", i), 32'(bus_a.tgt_ready), 1);
      check($sformatf("stall%0d_j", i), 32'(bus_a.j), 0);
      check($sformatf("stall%0d_k", i), 32'(bus_a.k), 0);
      if (i == 1) bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
    end
    check("stall_still_load", 32'(bus_a.tgt_ready), 1);
    check("start_busy_err_kept", 32'(bus_a.err_count), 1);
    d0 = done_a;
    send(0, 4'b0011, 1'b0, mk(4'b0011, 4'b1100, 4'b0011, 1'b0, 8'd1));
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(bus_a.busy), 0);
    check("midrst_tgt_ready", 32'(bus_a.tgt_ready), 0);
    check("midrst_j", 32'(bus_a.j), 0);
    check("midrst_k", 32'(bus_a.k), 0);
    check("midrst_err_count", 32'(bus_a.err_count), 0);
    check("midrst_mismatch", 32'(bus_a.mismatch), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_no_done", 32'(done_a), 32'(d0));
    check("midrst_no_mismatch", 32'(bus_a.mismatch), 0);

    // Toggle mode: 0000 (direct), 0011, 0110(last).
    pulse_start(1, t0);
    send(1, 4'b0000, 1'b0, mk(4'b0000, 4'b1111, 4'b0000, 1'b0, 8'd0));
    send(1, 4'b0011, 1'b0, mk(4'b0011, 4'b0011, 4'b0011, 1'b0, 8'd0));
    send(1, 4'b0110, 1'b1, mk(4'b0101, 4'b0101, 4'b0110, 1'b0, 8'd0));
    wait_done(1, t1);
    check("b_done_latency", 32'(t1 - t0), 10);
    @(negedge clk);
    check("b_final_q", 32'(flop_q_b), 32'(4'b0110));
    check("b_err_count", 32'(bus_b.err_count), 0);
    check("b_done_count", 32'(done_b), 1);

    check("a_scoreboard_drained", 32'(sb_a.size()), 0);
    check("b_scoreboard_drained", 32'(sb_b.size()), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
